alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared registered OR/AND/XOR/ADD unit
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0/req1              operation requests
//   op0/op1                opcode (00 OR, 01 AND, 10 XOR, 11 ADD)
//   a0/b0, a1/b1           operands per requester
//   gnt0/gnt1              one-cycle grant pulse (operands captured on that edge)
//   res, res_id, cout,     registered result, owner, carry-out, zero flag
//   zero
//   res_valid/res_ready    result handshake
// Option: define ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default fixed priority, requester 0 wins)
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] res,
  output logic             res_id,
  output logic             cout,
  output logic             zero,
  output logic             res_valid,
  input  logic             res_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic             r_id, r_cout, r_zero, r_valid;
  logic             w_sel, w_gnt0, w_gnt1;
  logic [WIDTH:0]   w_sum;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // r_last holds the last granted requester; resets to 1 so requester 0 wins first
  logic r_last;
  assign w_sel = req1 & (~req0 | ~r_last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= 1'b1;
    else if (w_gnt0 | w_gnt1) r_last <= w_gnt1;
`else
  assign w_sel = ~req0;
`endif
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: if (req0 | req1) begin
        w_next = EXEC;
        w_gnt0 = ~w_sel;
        w_gnt1 = w_sel;
      end
      EXEC: w_next = DONE;
      DONE: if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // grants are combinational; gating with rst_n keeps them low during reset even with requests pending
  assign gnt0 = w_gnt0 & rst_n;
  assign gnt1 = w_gnt1 & rst_n;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  always_comb
    w_res = r_op == 2'b00 ? r_a | r_b :
            r_op == 2'b01 ? r_a & r_b :
            r_op == 2'b10 ? r_a ^ r_b : w_sum[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt0 | w_gnt1) begin
        r_op <= w_sel ? op1 : op0;
        r_a  <= w_sel ? a1 : a0;
        r_b  <= w_sel ? b1 : b0;
        r_id <= w_sel;
      end
      if (r_state == EXEC) begin
        r_res   <= w_res;
        r_cout  <= r_op == 2'b11 ? w_sum[WIDTH] : 1'b0;
        r_zero  <= w_res == '0;
        r_valid <= 1'b1;
      end else if (r_state == DONE && res_ready) r_valid <= 1'b0;
    end
  assign res       = r_res;
  assign res_id    = r_valid ? r_id : r_id;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign res_valid = r_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, res_ready = 0;
  logic [1:0] op0 = 0, op1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic       gnt0, gnt1, res_id, cout, zero, res_valid;
  logic [7:0] res;
  int n_chk = 0, n_err = 0;
  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .res(res),
    .res_id(res_id), .cout(cout), .zero(zero), .res_valid(res_valid), .res_ready(res_ready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one complete operation with res_ready high: grant, execute, present, retire
  task automatic run_op(input string tag, input logic who, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_res, input logic e_cout, input logic e_zero);
    res_ready = 1;
    if (who) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    #1;
    chk({tag, "_gnt0"}, gnt0, !who);
    chk({tag, "_gnt1"}, gnt1, who);
    tick();
    req0 = 0; req1 = 0;
    a0 = 8'h55; b0 = 8'h55; a1 = 8'h55; b1 = 8'h55; op0 = 2'b10; op1 = 2'b10;
    chk({tag, "_gnt_exec"}, {gnt0, gnt1}, 2'b00);
    chk({tag, "_valid_exec"}, res_valid, 0);
    tick();
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_res"}, res, e_res);
    chk({tag, "_id"}, res_id, who);
    chk({tag, "_cout"}, cout, e_cout);
    chk({tag, "_zero"}, zero, e_zero);
    tick();
    chk({tag, "_valid_drop"}, res_valid, 0);
  endtask
  initial begin
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", {res_id, cout, zero, gnt0, gnt1}, 0);
    tick();
    rst_n = 1;
    tick();
    run_op("or", 0, 2'b00, 8'h87, 8'h0A, 8'h8F, 0, 0);
    run_op("add_wrap", 1, 2'b11, 8'hFF, 8'h7B, 8'h7A, 1, 0);
    run_op("add_zero", 1, 2'b11, 8'h01, 8'hFF, 8'h00, 1, 1);
    run_op("and", 1, 2'b01, 8'hF0, 8'h3C, 8'h30, 0, 0);
    run_op("xor", 1, 2'b10, 8'hF0, 8'h3C, 8'hCC, 0, 0);
    // contention: last grant went to requester 1, so round-robin starts with 0
    res_ready = 1;
    req0 = 1; op0 = 2'b00; a0 = 8'h01; b0 = 8'h02;
    req1 = 1; op1 = 2'b00; a1 = 8'h10; b1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      logic e = 1'(i % 2);
`else
      logic e = 1'b0;
`endif
      #1;
      chk($sformatf("cont%0d_gnt", i), {gnt0, gnt1}, {!e, e});
      tick();
      tick();
      chk($sformatf("cont%0d_id", i), res_id, e);
      chk($sformatf("cont%0d_res", i), res, e ? 8'h30 : 8'h03);
      tick();
    end
    req0 = 0; req1 = 0;
    tick();
    // backpressure
    res_ready = 0;
    req0 = 1; op0 = 2'b11; a0 = 8'h05; b0 = 8'h03;
    #1;
    chk("bp_gnt", gnt0, 1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), res_valid, 1);
      chk($sformatf("bp%0d_res", i), {res_id, res}, {1'b0, 8'h08});
      chk($sformatf("bp%0d_gnt", i), {gnt0, gnt1}, 2'b00);
      tick();
    end
    res_ready = 1;
    #1;
    chk("bp_valid_hold", res_valid, 1);
    tick();
    chk("bp_valid_drop", res_valid, 0);
    chk("bp_next_gnt", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0;
    tick();
    tick();
    chk("bp2_valid_drop", res_valid, 0);
    // reset while in EXEC, with both requests pending
    req1 = 1; op1 = 2'b00; a1 = 8'hAA; b1 = 8'h00;
    #1;
    chk("mid_gnt1", gnt1, 1);
    tick();
    req0 = 1;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("mid_rst_res", res, 0);
    #10;
    chk("mid_rst_hold", {res_valid, gnt0, gnt1}, 0);
    rst_n = 1;
    #1;
    chk("post_rst_gnt", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0; req1 = 0;
    tick();
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_id", res_id, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
